uart_tx_arbiter: RTL and testbench

//  Shares one 8N1 UART transmitter among NUM_REQ byte requesters. Picks requesters round-robin
//  and holds the grant for a whole packet, until a byte with last=1 is accepted. Sequences the

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: the transmitted byte
//   width, the arbiter FSM state encoding and the helper that sizes the
//   watchdog counter.
//   No ports (package).
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

  // Watchdog only has to count up to timeoutCyc-1, so clog2 bits suffice.
  function automatic int timeoutCntW(input int timeoutCyc);
    return $clog2(timeoutCyc);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. The search starts one position after
//   ptr_i and wraps modulo NUM_REQ, so the requester served last gets the
//   lowest priority next time.
//   Ports:
//     req_i   [NUM_REQ-1:0]  requester mask to choose from
//     ptr_i   [IDW-1:0]      index of the most recently served requester
//     grant_o [NUM_REQ-1:0]  one-hot selection (all zero when nothing requested)
//     idx_o   [IDW-1:0]      index of the selection
//     any_o                  at least one requester selected
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Walk candidates ptr+1, ptr+2, ... ptr+NUM_REQ (the last one is ptr itself,
  // so a lone requester can be served twice in a row). First hit wins.
  always_comb begin
    logic [IDW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 UART transmitter among NUM_REQ byte requesters. Requesters
//   are picked round-robin and a grant is held for a whole packet (until a
//   byte with last=1 is accepted). Each accepted byte is launched with a
//   one-cycle start pulse and the arbiter waits for done; a watchdog aborts
//   the wait if done never arrives.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     req_valid/last      per-requester byte valid and end-of-packet flag
//     req_data            flattened bytes, requester i at [8*i+7:8*i]
//     req_ready           one-hot accept, transfer when valid & ready
//     uart_tx_start       one-cycle launch pulse to the transmitter
//     uart_tx_data        byte to the transmitter, stable from start to done
//     uart_tx_done        one-cycle completion pulse from the transmitter
//     grant_id            index of the last accepted requester
//     busy                high whenever the FSM is not arbitrating
//     timeout_err         one-cycle pulse on watchdog abort
//     bytes_sent          completed byte count, wraps at 2^16
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           uart_tx_start,
  output logic [UART_DATA_W-1:0]         uart_tx_data,
  input  logic                           uart_tx_done,
  output logic [IDW-1:0]                 grant_id,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [15:0]                    bytes_sent
);

  localparam int             WDW       = timeoutCntW(TIMEOUT_CYC);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic                   lock_q, lock_d;
  logic [IDW-1:0]         lockId_q, lockId_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic [UART_DATA_W-1:0] txData_q, txData_d;
  logic [IDW-1:0]         grantId_q, grantId_d;
  logic                   timeoutErr_q, timeoutErr_d;
  logic [15:0]            bytesSent_q, bytesSent_d;

  logic [NUM_REQ-1:0] lockMask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pickOnehot;
  logic [IDW-1:0]     pickIdx;
  logic               pickAny;

  // While a packet is in progress only its owner may be chosen; if the owner
  // drops valid mid-packet everyone else stalls until it comes back.
  assign lockMask = {{(NUM_REQ-1){1'b0}}, 1'b1} << lockId_q;
  assign eligible = lock_q ? (lockMask & req_valid) : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) uRr (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (pickOnehot),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

  // Ready is combinational so a requester is accepted in the same cycle it is
  // chosen; reset masks it so nothing is acknowledged that will be dropped.
  assign req_ready = (state_q == ARB && !reset) ? pickOnehot : '0;

  assign uart_tx_start = (state_q == LAUNCH);
  assign uart_tx_data  = txData_q;
  assign grant_id      = grantId_q;
  assign busy          = (state_q != ARB);
  assign timeout_err   = timeoutErr_q;
  assign bytes_sent    = bytesSent_q;

  // Next-state logic. Done has priority over watchdog expiry, and done seen
  // outside WAIT falls through the defaults and is ignored. On abort the
  // pointer moves to the stuck requester so it loses priority next round.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_d       = lock_q;
    lockId_d     = lockId_q;
    wdog_d       = wdog_q;
    txData_d     = txData_q;
    grantId_d    = grantId_q;
    timeoutErr_d = 1'b0;
    bytesSent_d  = bytesSent_q;
    case (state_q)
      ARB: begin
        if (pickAny) begin
          txData_d  = req_data[int'(pickIdx)*UART_DATA_W +: UART_DATA_W];
          grantId_d = pickIdx;
          state_d   = LAUNCH;
          if (req_last[pickIdx]) begin
            lock_d = 1'b0;
            ptr_d  = pickIdx;
          end else begin
            lock_d   = 1'b1;
            lockId_d = pickIdx;
          end
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (uart_tx_done) begin
          bytesSent_d = bytesSent_q + 16'd1;
          state_d     = ARB;
        end else if (wdog_q == WDOG_LAST) begin
          timeoutErr_d = 1'b1;
          lock_d       = 1'b0;
          ptr_d        = grantId_q;
          state_d      = ARB;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State register; the pointer resets to the last index so the very first
  // search begins at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      ptr_q        <= IDW'(NUM_REQ - 1);
      lock_q       <= 1'b0;
      lockId_q     <= '0;
      wdog_q       <= '0;
      txData_q     <= '0;
      grantId_q    <= '0;
      timeoutErr_q <= 1'b0;
      bytesSent_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lock_q       <= lock_d;
      lockId_q     <= lockId_d;
      wdog_q       <= wdog_d;
      txData_q     <= txData_d;
      grantId_q    <= grantId_d;
      timeoutErr_q <= timeoutErr_d;
      bytesSent_q  <= bytesSent_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Directed scenarios plus a
//   randomized run; a transaction-level reference model (queues per
//   requester, round-robin pointer and packet lock as plain integers)
//   predicts every accept. Inputs change on the falling edge and outputs
//   are sampled 1 time unit later.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            uart_tx_start;
  logic [7:0]      uart_tx_data;
  logic            uart_tx_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     bytes_sent;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  int         mPtr, mLock, mLockId, mBytes;
  logic [7:0] qData [NR][$];
  logic       qLast [NR][$];
  int         obsGrants[$];
  int         obsStarts;
  logic       alwaysPresent;
  logic [NR-1:0] present;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TO),
    .IDW         (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_done  (uart_tx_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .bytes_sent    (bytes_sent)
  );

  // Round-robin choice from the rules: locked owner only, else first valid
  // requester after the last one served.
  function automatic int modelPick(input logic [NR-1:0] valid);
    logic [NR-1:0] elig;
    elig = valid;
    if (mLock != 0) elig = valid & (NR'(1) << mLockId);
    for (int k = 1; k <= NR; k++) begin
      if (elig[(mPtr + k) % NR]) return (mPtr + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit allEmpty();
    for (int i = 0; i < NR; i++) if (qData[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    tick();
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_tx_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mPtr = NR - 1; mLock = 0; mLockId = 0; mBytes = 0;
    for (int i = 0; i < NR; i++) begin qData[i].delete(); qLast[i].delete(); end
    obsGrants.delete(); obsStarts = 0; present = '0;
  endtask

  // Requesters present queued bytes (randomly gapped unless alwaysPresent),
  // the bench acts as the transmitter with random done latency.
  task automatic runEngine(input int budget, input int maxDelay);
    int phase, waitCnt, delay, expSel, cycles, sel;
    logic [7:0]    expByte;
    logic [NR-1:0] expReady;
    phase = 0; waitCnt = 0; delay = 0; expSel = 0; cycles = 0; expByte = '0;
    while (cycles < budget && !(phase == 0 && allEmpty())) begin
      tick(); cycles++;
      for (int i = 0; i < NR; i++) begin
        if (qData[i].size() != 0 && !present[i] && (alwaysPresent || $urandom_range(0, 2) != 0))
          present[i] = 1'b1;
        req_valid[i] = present[i];
        req_data[8*i +: 8] = present[i] ? qData[i][0] : 8'($urandom);
        req_last[i] = present[i] ? qLast[i][0] : 1'b0;
      end
      if (phase == 2) uart_tx_done = (waitCnt == delay);
      else uart_tx_done = !alwaysPresent && ($urandom_range(0, 3) == 0);
      #1;
      if (uart_tx_start) obsStarts++;
      nCompared++;
      if (bytes_sent !== 16'(mBytes)) begin
        nMismatched++; $display("[TB] FAIL eng_bytes_sent: got %0d want %0d", bytes_sent, mBytes);
      end
      case (phase)
        0: begin
          sel = modelPick(req_valid);
          expReady = (sel >= 0) ? (NR'(1) << sel) : '0;
          nCompared++;
          if (req_ready !== expReady || busy !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL eng_ready: got %b busy %b want %b busy 0", req_ready, busy, expReady);
          end
          if (sel >= 0) begin
            expSel = sel;
            expByte = qData[sel].pop_front();
            if (qLast[sel].pop_front()) begin mLock = 0; mPtr = sel; end
            else begin mLock = 1; mLockId = sel; end
            present[sel] = 1'b0;
            phase = 1;
          end
        end
        1: begin
          obsGrants.push_back(int'(grant_id));
          nCompared++;
          if (uart_tx_start !== 1'b1 || uart_tx_data !== expByte || grant_id !== 2'(expSel)) begin
            nMismatched++;
            $display("[TB] FAIL eng_launch: got start %b data %h id %0d want start 1 data %h id %0d",
                     uart_tx_start, uart_tx_data, grant_id, expByte, expSel);
          end
          phase = 2; waitCnt = 0; delay = $urandom_range(0, maxDelay);
        end
        default: begin
          nCompared++;
          if (uart_tx_start !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL eng_wait: got start %b busy %b err %b want 0 1 0", uart_tx_start, busy, timeout_err);
          end
          if (uart_tx_done) begin mBytes++; phase = 0; end
          else waitCnt++;
        end
      endcase
    end
    nCompared++;
    if (!(phase == 0 && allEmpty())) begin
      nMismatched++; $display("[TB] FAIL eng_budget: got phase %0d after %0d cycles want all drained", phase, cycles);
    end
    tick(); req_valid = '0; uart_tx_done = 1'b0; #1;
    nCompared++;
    if (bytes_sent !== 16'(mBytes) || busy !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL eng_final: got bytes %0d busy %b want %0d busy 0", bytes_sent, busy, mBytes);
    end
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1; req_valid = 4'hF; req_data = 32'($urandom); req_last = 4'hF; uart_tx_done = 1'b0;
    tick(); tick(); #1;
    nCompared++;
    if (req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
    nCompared++;
    if (busy !== 1'b0 || uart_tx_start !== 1'b0 || timeout_err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_flags: got busy %b start %b err %b want 0 0 0", busy, uart_tx_start, timeout_err);
    end
    nCompared++;
    if (uart_tx_data !== 8'h00 || grant_id !== 2'd0 || bytes_sent !== 16'd0) begin
      nMismatched++; $display("[TB] FAIL reset_regs: got data %h id %0d bytes %0d want 0 0 0", uart_tx_data, grant_id, bytes_sent);
    end
  endtask

  task automatic test_single();
    doReset();
    tick(); req_valid = 4'b0001; req_data = 32'h0000_00A5; req_last = 4'b0001; #1;
    nCompared++;
    if (req_ready !== 4'b0001) begin nMismatched++; $display("[TB] FAIL single_ready: got %b want 0001", req_ready); end
    tick(); req_valid = '0; #1;
    nCompared++;
    if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'hA5 || busy !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL single_start: got start %b data %h busy %b want 1 a5 1", uart_tx_start, uart_tx_data, busy);
    end
    tick(); #1;
    nCompared++;
    if (uart_tx_start !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_pulse: got start %b want 0", uart_tx_start); end
    tick(); uart_tx_done = 1'b1;
    tick(); uart_tx_done = 1'b0; #1;
    nCompared++;
    if (busy !== 1'b0 || bytes_sent !== 16'd1) begin
      nMismatched++; $display("[TB] FAIL single_done: got busy %b bytes %0d want 0 1", busy, bytes_sent);
    end
  endtask

  task automatic test_round_robin();
    int expOrder[5] = '{0, 1, 2, 3, 0};
    doReset(); alwaysPresent = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin qData[i].push_back(8'($urandom)); qLast[i].push_back(1'b1); end
    runEngine(400, 4);
    for (int k = 0; k < 5; k++) begin
      nCompared++;
      if (k >= obsGrants.size() || obsGrants[k] != expOrder[k]) begin
        nMismatched++;
        $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", k, (k < obsGrants.size()) ? obsGrants[k] : -1, expOrder[k]);
      end
    end
    nCompared++;
    if (obsStarts != 8 || bytes_sent !== 16'd8) begin
      nMismatched++; $display("[TB] FAIL rr_starts: got starts %0d bytes %0d want 8 8", obsStarts, bytes_sent);
    end
  endtask

  task automatic test_packet_lock();
    int expOrder[4] = '{1, 1, 1, 2};
    doReset(); alwaysPresent = 1'b1;
    qData[1].push_back(8'h11); qLast[1].push_back(1'b0);
    qData[1].push_back(8'h22); qLast[1].push_back(1'b0);
    qData[1].push_back(8'h33); qLast[1].push_back(1'b1);
    qData[2].push_back(8'h44); qLast[2].push_back(1'b1);
    runEngine(400, 4);
    for (int k = 0; k < 4; k++) begin
      nCompared++;
      if (k >= obsGrants.size() || obsGrants[k] != expOrder[k]) begin
        nMismatched++;
        $display("[TB] FAIL lock_order[%0d]: got %0d want %0d", k, (k < obsGrants.size()) ? obsGrants[k] : -1, expOrder[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int badWait;
    doReset();
    tick(); req_valid = 4'b0001; req_data = 32'h0000_005A; req_last = 4'b0000; #1;
    nCompared++;
    if (req_ready !== 4'b0001) begin nMismatched++; $display("[TB] FAIL to_ready: got %b want 0001", req_ready); end
    tick(); req_valid = '0; #1;
    badWait = 0;
    for (int k = 1; k <= TO; k++) begin
      tick(); #1;
      if (busy !== 1'b1 || timeout_err !== 1'b0) badWait++;
    end
    nCompared++;
    if (badWait != 0) begin nMismatched++; $display("[TB] FAIL to_wait: got %0d bad WAIT cycles want 0", badWait); end
    tick(); req_valid = 4'b0110; req_data = 32'h00C3_B200; req_last = 4'b0110; #1;
    nCompared++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || bytes_sent !== 16'd0) begin
      nMismatched++; $display("[TB] FAIL to_abort: got err %b busy %b bytes %0d want 1 0 0", timeout_err, busy, bytes_sent);
    end
    nCompared++;
    if (req_ready !== 4'b0010) begin nMismatched++; $display("[TB] FAIL to_unlock: got %b want 0010", req_ready); end
    tick(); req_valid = '0; #1;
    nCompared++;
    if (timeout_err !== 1'b0 || uart_tx_start !== 1'b1 || grant_id !== 2'd1 || uart_tx_data !== 8'hB2) begin
      nMismatched++;
      $display("[TB] FAIL to_next: got err %b start %b id %0d data %h want 0 1 1 b2", timeout_err, uart_tx_start, grant_id, uart_tx_data);
    end
    tick(); uart_tx_done = 1'b1;
    tick(); uart_tx_done = 1'b0; #1;
    nCompared++;
    if (bytes_sent !== 16'd1) begin nMismatched++; $display("[TB] FAIL to_count: got %0d want 1", bytes_sent); end
  endtask

  task automatic test_done_outside();
    doReset();
    tick(); uart_tx_done = 1'b1; req_valid = '0;
    tick(); uart_tx_done = 1'b0; #1;
    nCompared++;
    if (bytes_sent !== 16'd0 || busy !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL idle_done: got bytes %0d busy %b want 0 0", bytes_sent, busy);
    end
    tick(); req_valid = 4'b0100; req_data = 32'h0077_0000; req_last = 4'b0100;
    tick(); req_valid = '0; uart_tx_done = 1'b1; #1;
    nCompared++;
    if (uart_tx_start !== 1'b1) begin nMismatched++; $display("[TB] FAIL coin_start: got %b want 1", uart_tx_start); end
    for (int k = 1; k <= TO; k++) begin
      tick(); uart_tx_done = (k == TO); #1;
      if (k == 1) begin
        nCompared++;
        if (bytes_sent !== 16'd0) begin nMismatched++; $display("[TB] FAIL launch_done: got %0d want 0", bytes_sent); end
      end
    end
    tick(); uart_tx_done = 1'b0; #1;
    nCompared++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || bytes_sent !== 16'd1) begin
      nMismatched++; $display("[TB] FAIL coin_done: got err %b busy %b bytes %0d want 0 0 1", timeout_err, busy, bytes_sent);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    tick(); req_valid = 4'b0100; req_data = 32'h003C_0000; req_last = 4'b0100;
    tick(); req_valid = '0;
    tick(); uart_tx_done = 1'b1;
    tick(); uart_tx_done = 1'b0; #1;
    nCompared++;
    if (bytes_sent !== 16'd1 || grant_id !== 2'd2) begin
      nMismatched++; $display("[TB] FAIL mid_pre: got bytes %0d id %0d want 1 2", bytes_sent, grant_id);
    end
    tick(); req_valid = 4'b0100; req_data = 32'h003D_0000;
    tick(); req_valid = '0;
    tick(); tick(); reset = 1'b1; req_valid = 4'b1000;
    tick(); #1;
    nCompared++;
    if (busy !== 1'b0 || uart_tx_start !== 1'b0 || bytes_sent !== 16'd0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL mid_reset: got busy %b start %b bytes %0d id %0d ready %b want 0 0 0 0 0000",
               busy, uart_tx_start, bytes_sent, grant_id, req_ready);
    end
    tick(); reset = 1'b0; req_valid = 4'b1000; req_data = 32'hE700_0000; req_last = 4'b1000; #1;
    nCompared++;
    if (req_ready !== 4'b1000) begin nMismatched++; $display("[TB] FAIL mid_grant: got %b want 1000", req_ready); end
    tick(); req_valid = '0; #1;
    nCompared++;
    if (uart_tx_start !== 1'b1 || grant_id !== 2'd3 || uart_tx_data !== 8'hE7) begin
      nMismatched++; $display("[TB] FAIL mid_start: got start %b id %0d data %h want 1 3 e7", uart_tx_start, grant_id, uart_tx_data);
    end
    tick(); uart_tx_done = 1'b1;
    tick(); uart_tx_done = 1'b0;
  endtask

  task automatic test_random();
    int len;
    for (int round = 0; round < 3; round++) begin
      doReset(); alwaysPresent = 1'b0;
      for (int i = 0; i < NR; i++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            qData[i].push_back(8'($urandom));
            qLast[i].push_back(b == len - 1);
          end
        end
      end
      runEngine(4000, 8);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_tx_done = 1'b0;
    alwaysPresent = 1'b0; present = '0; obsStarts = 0;
    mPtr = NR - 1; mLock = 0; mLockId = 0; mBytes = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_done_outside();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_time_limit: got no finish want finish before 900000");
    $fatal(1, "[TB] time limit");
  end

endmodule
